serial_adder: RTL

- Bit-serial, LSB-first multi-cycle adder built around a single full-adder cell (two half-adder stages) and a carry flip-flop.
- Adds two WIDTH-bit unsigned operands plus carry-in, one bit per clock.
- Sits directly downstream of the combinational adder cells and consumes their sum and carry each cycle.
- Used where area matters more than latency; start/busy/done handshake to the controlling logic.

---
 rtl/serial_adder_pkg.sv | 14 +
 rtl/serial_fa_cell.sv | 20 ++
 rtl/serial_adder.sv | 96 +++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and the
// rule for sizing the bit counter.
package serial_adder_pkg;

  localparam logic [1:0] SA_IDLE  = 2'd0;
  localparam logic [1:0] SA_SHIFT = 2'd1;
  localparam logic [1:0] SA_DONE  = 2'd2;

  // Counter must index bits 0..width-1; never let it collapse to zero bits.
  function automatic int sa_cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// Combinational full adder built from two half-adder stages and an OR.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g1;
  logic g2;

  assign p  = a ^ b;
  assign g1 = a & b;
  assign s  = p ^ ci;
  assign g2 = p & ci;
  assign co = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop, WIDTH cycles per add.
// Define SERIAL_ADDER_SAT_EN to saturate sum to all ones when the final carry is set.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = sa_cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] sum_next;

  serial_fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  // The current bit lands in the MSB; after the last bit the full result is res_next.
  always_comb begin
    res_next = {fa_s, res_sr};
`ifdef SERIAL_ADDER_SAT_EN
    sum_next = fa_co ? '1 : res_next;
`else
    sum_next = res_next;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= SA_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        SA_IDLE, SA_DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            count <= '0;
            state <= SA_SHIFT;
          end else begin
            state <= SA_IDLE;
          end
        end
        SA_SHIFT: begin
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          res_sr <= res_next[WIDTH-1:1];
          carry  <= fa_co;
          count  <= count + CW'(1);
          // Outputs only move here, so partial results are never visible.
          if (count == LAST) begin
            sum   <= sum_next;
            cout  <= fa_co;
            state <= SA_DONE;
          end
        end
        default: state <= SA_IDLE;
      endcase
    end
  end

  assign busy = (state == SA_SHIFT);
  assign done = (state == SA_DONE);

endmodule
